// File: rtl/control_multi_if.sv
// Control bundle between the multicycle sequencer and the shared datapath.
// The datapath drives the opcode and memory ready; the sequencer drives the strobes.
interface control_multi_if;
  logic [6:0]  iOp;
  logic        iMemReady;
  logic        oPCWrite;
  logic        oPCWriteCond;
  logic [1:0]  oPCSource;
  logic        oIorD;
  logic        oMemRead;
  logic        oMemWrite;
  logic        oIRWrite;
  logic        oRegWrite;
  logic [1:0]  oMemtoReg;
  logic [1:0]  oALUSrcA;
  logic [1:0]  oALUSrcB;
  logic [1:0]  oALUOp;
  logic [3:0]  oState;
  logic [31:0] oInstCount;
  logic        oIllegal;

  modport slave (
    input  iOp, iMemReady,
    output oPCWrite, oPCWriteCond, oPCSource,
    output oIorD, oMemRead, oMemWrite, oIRWrite,
    output oRegWrite, oMemtoReg,
    output oALUSrcA, oALUSrcB, oALUOp,
    output oState, oInstCount, oIllegal
  );

  modport master (
    output iOp, iMemReady,
    input  oPCWrite, oPCWriteCond, oPCSource,
    input  oIorD, oMemRead, oMemWrite, oIRWrite,
    input  oRegWrite, oMemtoReg,
    input  oALUSrcA, oALUSrcB, oALUOp,
    input  oState, oInstCount, oIllegal
  );
endinterface

// File: rtl/control_multi.sv
// Multicycle RISC-V control sequencer: Moore FSM with registered strobes,
// memory-ready gating of the fetch loads, retire counter and sticky trap.
module control_multi (
  input logic        iClk,
  input logic        iClr,
  control_multi_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    LOADWB   = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    ALUWB    = 4'd7,
    EXEC_I   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    AUIPC    = 4'd11,
    LUI      = 4'd12,
    TRAP     = 4'd13,
    BAD14    = 4'd14,
    BAD15    = 4'd15
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcCond;
    logic [1:0] pcSrc;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       fetch;
    logic       regWrite;
    logic [1:0] memtoReg;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [1:0] aluOp;
  } ctrl_t;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic [31:0] count;
  logic        illegal;
  logic        retire;

  function automatic state_t nextOf(state_t s, logic [6:0] op, logic rdy);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:    n = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          7'b0000011,
          7'b0100011: n = MEMADDR;
          7'b0110011: n = EXEC_R;
          7'b0010011: n = EXEC_I;
          7'b1100011: n = BRANCH;
          7'b1101111: n = JAL;
          7'b0010111: n = AUIPC;
          7'b0110111: n = LUI;
          default:    n = TRAP;
        endcase
      end
      MEMADDR:  n = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
      MEMREAD:  n = rdy ? LOADWB : MEMREAD;
      MEMWRITE: n = rdy ? FETCH : MEMWRITE;
      EXEC_R:   n = ALUWB;
      EXEC_I:   n = ALUWB;
      AUIPC:    n = ALUWB;
      LUI:      n = ALUWB;
      TRAP:     n = TRAP;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t ctrlFor(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memRead = 1'b1;
        c.srcB    = 2'b01;
        c.fetch   = 1'b1;
      end
      DECODE: begin
        c.srcA = 2'b10;
        c.srcB = 2'b10;
      end
      MEMADDR: begin
        c.srcA = 2'b01;
        c.srcB = 2'b10;
      end
      MEMREAD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      LOADWB: begin
        c.regWrite = 1'b1;
        c.memtoReg = 2'b01;
      end
      MEMWRITE: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      EXEC_R: begin
        c.srcA  = 2'b01;
        c.aluOp = 2'b10;
      end
      ALUWB:  c.regWrite = 1'b1;
      EXEC_I: begin
        c.srcA  = 2'b01;
        c.srcB  = 2'b10;
        c.aluOp = 2'b11;
      end
      BRANCH: begin
        c.srcA   = 2'b01;
        c.aluOp  = 2'b01;
        c.pcCond = 1'b1;
        c.pcSrc  = 2'b01;
      end
      JAL: begin
        c.regWrite = 1'b1;
        c.memtoReg = 2'b10;
        c.pcWrite  = 1'b1;
        c.pcSrc    = 2'b01;
      end
      AUIPC: begin
        c.srcA = 2'b10;
        c.srcB = 2'b10;
      end
      LUI: begin
        c.srcA = 2'b11;
        c.srcB = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign nxt = nextOf(state, bus.iOp, bus.iMemReady);

  assign retire = (state == LOADWB) || (state == ALUWB) ||
                  (state == BRANCH) || (state == JAL) ||
                  ((state == MEMWRITE) && bus.iMemReady);

  // State, strobes for the next state, retire count and trap flag.
  always_ff @(posedge iClk) begin
    if (iClr) begin
      state   <= FETCH;
      ctrl    <= ctrlFor(FETCH);
      count   <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= nxt;
      ctrl    <= ctrlFor(nxt);
      count   <= count + {31'd0, retire};
      illegal <= illegal | (nxt == TRAP);
    end
  end

  assign bus.oPCWrite     = ctrl.pcWrite | (ctrl.fetch & bus.iMemReady);
  assign bus.oIRWrite     = ctrl.fetch & bus.iMemReady;
  assign bus.oPCWriteCond = ctrl.pcCond;
  assign bus.oPCSource    = ctrl.pcSrc;
  assign bus.oIorD        = ctrl.iorD;
  assign bus.oMemRead     = ctrl.memRead;
  assign bus.oMemWrite    = ctrl.memWrite;
  assign bus.oRegWrite    = ctrl.regWrite;
  assign bus.oMemtoReg    = ctrl.memtoReg;
  assign bus.oALUSrcA     = ctrl.srcA;
  assign bus.oALUSrcB     = ctrl.srcB;
  assign bus.oALUOp       = ctrl.aluOp;
  assign bus.oState       = state;
  assign bus.oInstCount   = count;
  assign bus.oIllegal     = illegal;

endmodule

// File: doc/control_multi.md
# control_multi

Multicycle control unit for the RISC-V core. It sequences the shared datapath (ALU, register bank, single unified memory port, PC/IR registers) through fetch, decode, execute, memory and writeback steps. It replaces the single-cycle decoder. The block is a Moore FSM with Mealy gating on a memory-ready handshake. It also counts retired instructions and latches an illegal-opcode trap.

## Interface
Parameters:
- none

Ports (clock and reset first):
- iClk  in  1  system clock; all state changes on rising edge
- iClr  in  1  reset, synchronous, active-high
- iOp  in  7  opcode field from IR (bits 6:0); stable from DECODE onward
- iMemReady  in  1  memory has completed the current request this cycle
- oPCWrite  out  1  unconditional PC load
- oPCWriteCond  out  1  PC load if the datapath's ALU zero flag is set
- oPCSource  out  2  00 ALU result, 01 ALUOut register
- oIorD  out  1  memory address: 0 PC, 1 ALUOut
- oMemRead  out  1  memory read request
- oMemWrite  out  1  memory write request
- oIRWrite  out  1  load IR (and OldPC) from memory data
- oRegWrite  out  1  register bank write enable
- oMemtoReg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC
- oALUSrcA  out  2  00 PC, 01 rs1, 10 OldPC, 11 zero
- oALUSrcB  out  2  00 rs2, 01 constant 4, 10 immediate
- oALUOp  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- oState  out  4  current state encoding (debug)
- oInstCount  out  32  retired-instruction counter
- oIllegal  out  1  sticky trap flag

## Operation
- The states and encodings are listed below. Any output not listed for a state is 0.
- 0 FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite both equal iMemReady.
  - Next state: DECODE if iMemReady, else stay in FETCH.
- 1 DECODE:
  - Outputs: ALUSrcA=10, ALUSrcB=10, ALUOp=00. This forms the branch/jump target in ALUOut.
  - Next state by iOp:
    - 0000011 or 0100011 → MEMADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0010111 → AUIPC
    - 0110111 → LUI
    - anything else (including JALR) → TRAP
- 2 MEMADDR:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00.
  - Next state: MEMREAD if iOp=0000011, else MEMWRITE.
- 3 MEMREAD:
  - Outputs: MemRead=1, IorD=1.
  - Next state: LOADWB if iMemReady, else stay.
- 4 LOADWB: RegWrite=1, MemtoReg=01. Next state: FETCH.
- 5 MEMWRITE:
  - Outputs: MemWrite=1, IorD=1.
  - Next state: FETCH if iMemReady, else stay.
- 6 EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Next state: ALUWB.
- 7 ALUWB: RegWrite=1, MemtoReg=00. Next state: FETCH.
- 8 EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=11. Next state: ALUWB.
- 9 BRANCH:
  - Outputs: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Next state: FETCH.
- 10 JAL:
  - Outputs: RegWrite=1, MemtoReg=10 (PC already holds PC+4), PCWrite=1, PCSource=01.
  - Next state: FETCH.
- 11 AUIPC: ALUSrcA=10, ALUSrcB=10, ALUOp=00. Next state: ALUWB.
- 12 LUI: ALUSrcA=11, ALUSrcB=10, ALUOp=00. Next state: ALUWB.
- 13 TRAP:
  - oIllegal=1, all strobes 0.
  - The FSM stays in TRAP until iClr.
- Encodings 14 and 15 are unreachable. If entered, the next state is FETCH.
- oInstCount:
  - Increments by 1 on every edge that leaves LOADWB, ALUWB, BRANCH, JAL, or leaves MEMWRITE with iMemReady=1.
  - It wraps 0xFFFFFFFF → 0. TRAP does not count.
- oIllegal is set on the edge entering TRAP and held until reset.

## Timing
- Reset: iClr sampled high at an edge forces, after that edge, state=FETCH, oInstCount=0, oIllegal=0.
  - iClr has priority over every transition, including mid-memory-wait and TRAP.
  - Output values after reset are the FETCH decode: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=iMemReady, all other outputs 0, oState=0.
- Instruction latency with zero memory wait (iMemReady held at 1), counted from FETCH entry to the next FETCH:
  - R/I/AUIPC/LUI: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL: 3 cycles
- Each cycle that iMemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
  - Request strobes stay constant during the wait.
  - oIRWrite and oPCWrite stay 0 until the ready cycle.
- Memory handshake: the request is held until iMemReady=1 is sampled at an edge. iMemReady is ignored in every other state.
- oState and all control outputs change only after a rising edge, except the FETCH gating by iMemReady, which is combinational.

## Test plan
- Reset then ADD (iOp=0110011), iMemReady=1 → states 0,1,6,7,0; RegWrite high only in state 7; oInstCount=1.
- LW with iMemReady low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0; MemRead/IorD=1 held throughout; 7 cycles total; count increments once.
- Fetch wait: iMemReady=0 for 3 cycles in FETCH → IRWrite/PCWrite stay 0 until the 4th cycle, then a single-cycle pulse of each.
- BRANCH and JAL → BRANCH asserts PCWriteCond=1 with PCSource=01 in state 9; JAL asserts RegWrite, MemtoReg=10 and PCWrite in state 10; each takes 3 cycles.
- iOp=1100111 (JALR) → TRAP (13), oIllegal=1, held for 20 cycles, count frozen; iClr → FETCH, oIllegal=0, count 0.
- iClr asserted in MEMWRITE while waiting → next state FETCH, MemWrite drops, no count increment.
